regbank_mp: RTL
===============

# regbank_mp

Parametrised multi-read-port register bank for the CPU pipeline. Holds NREGS general-purpose registers of DATA_W bits. Offers NRD independently controlled registered read ports with same-cycle write bypass, byte-enabled writes and a hardwired-zero register 0. It feeds the operand-fetch stage and accepts writeback from the final pipeline stage.

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- NREGS, 16: number of registers; must be a power of two, at least 2.
- NRD, 2: number of read ports, 1 to 4.
- ADDR_W, $clog2(NREGS): derived localparam, not overridable.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_hold  in  NRD  per-port hold of the output value.
- rd_clear  in  NRD  per-port forced zero of the output.
- rd_data  out  NRD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W].
- wr_en  in  1  write strobe for port 1.
- wr_addr  in  ADDR_W  write address for port 1.
- wr_data  in  DATA_W  write data for port 1.
- wr_be  in  DATA_W/8  byte enables for port 1; bit k covers data bits [8k+7:8k].
- wr2_en, wr2_addr, wr2_data  in  1/ADDR_W/DATA_W  second write port, full word only; present only with REGBANK_WR2_EN.

## Operation
- Storage array of NREGS×DATA_W. The array is not reset, so contents are undefined until written.
- Writes are accepted on the clock edge when wr_en=1, reset=0 and wr_addr≠0. Only bytes with wr_be set are updated.
- Writes to register 0 are ignored. Writes issued while reset=1 are ignored.
- Each read port updates its output register on every clock edge using this priority:
  1. reset: output becomes 0.
  2. rd_clear[i]: output becomes 0.
  3. rd_hold[i]: output keeps its current value, even if the addressed register is written meanwhile.
  4. rd_addr=0: output becomes 0.
  5. Address matches an active write: output takes the bypass-merged value. Bytes with wr_be set come from wr_data; the remaining bytes come from the array.
  6. Otherwise: output takes the array value.
- Read ports are fully independent; any number of ports may address the same register.
- Port i's behaviour depends only on its own hold and clear bits.

## Timing
- rd_data reset value: all zeros.
- Read latency is 1 cycle. An address presented in cycle N appears on rd_data in cycle N+1.
- A write in cycle N is visible through bypass to a read addressed in cycle N, i.e. in rd_data at N+1. It is visible through the array to a read addressed in cycle N+1 or later.
- rd_data is a function of flops only. There is no combinational path from any input to rd_data.
- If reset is asserted mid-stream, all outputs are 0 in the next cycle. Array contents written before reset are retained.
- Hold released in cycle N: the port resumes normal priority, using rd_addr at cycle N.

## Configuration
- REGBANK_WR2_EN defined: a second write port is added.
  - Same write rules as port 1, full-word write.
  - Same-address collision with port 1: wr2 wins for all bytes, both in the array and in the bypass.
  - Bypass priority for reads: wr2, then port 1 byte-merge, then array.
- REGBANK_WR2_EN not defined: the wr2_* ports do not exist, and behaviour is exactly as described above.

## Structure
- Package regbank_pkg holds:
  - default DATA_W, NREGS and NRD constants;
  - a byte-merge function (old word, new word, byte enables) → merged word, shared by the write path and the bypass path.
- Sub-module regbank_rdport: one read port's priority, hold, clear, zero and bypass logic plus its output register. It is instantiated NRD times by a generate loop.
- The array and the write logic stay in the top module.

## Test plan
- Reset, then write r3=0xDEADBEEF with wr_be=4'hF. Read r3 on port 0 the next cycle → 0xDEADBEEF at +1 cycle. rd_data must read 0 during reset.
- r5=0x11223344, then in the same cycle write r5=0xAABBCCDD with wr_be=4'b0101 and read r5 → 0x11BB33DD via bypass; the array then holds 0x11BB33DD.
- Write r0=0xFFFFFFFF, then read r0 on all ports → 0 everywhere.
- Port 1 held while r7 is rewritten from 0x1 to 0x2 → port 1 stays 0x1. Release hold → 0x2 one cycle later. Port 0 reads 0x2 throughout.
- Assert rd_clear[0] and rd_hold[0] together → port 0 gives 0. Assert reset during a write to r4 → write ignored, r4 keeps its old value.
- With REGBANK_WR2_EN, write r9=0x5 on port 1 and r9=0x6 on wr2 while reading r9 in the same cycle → read 0x6, then the array holds 0x6.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and the byte-merge helper for the multi-port register bank.
// The same merge is used by the array write path and by the read-port bypass.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 2;

  // Merge operates on a fixed wide word; callers size-cast in and out.
  localparam int MERGE_W  = 256;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < MERGE_BE; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regbank_rdport.sv
// One registered read port: reset/clear/hold/zero priority and same-cycle write bypass.
// With REGBANK_WR2_EN the full-word second write port takes bypass priority.
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                hold,
  input  logic                clear,
  input  logic [DATA_W-1:0]   arr_word,
  input  logic                wr_act,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
`ifdef REGBANK_WR2_EN
  input  logic                wr2_act,
  input  logic [ADDR_W-1:0]   wr2_addr,
  input  logic [DATA_W-1:0]   wr2_data,
`endif
  output logic [DATA_W-1:0]   data
);

  logic [DATA_W-1:0] bypass;

  always_comb begin
    bypass = arr_word;
    if (wr_act && (wr_addr == addr)) begin
      bypass = DATA_W'(byte_merge(MERGE_W'(arr_word), MERGE_W'(wr_data), MERGE_BE'(wr_be)));
    end
`ifdef REGBANK_WR2_EN
    if (wr2_act && (wr2_addr == addr)) bypass = wr2_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data <= '0;
    end else if (!hold) begin
      data <= (addr == '0) ? '0 : bypass;
    end
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-read-port register bank with byte-enabled write and hardwired-zero r0.
// Optional second full-word write port enabled by defining REGBANK_WR2_EN.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  NREGS  = DEF_NREGS,
  parameter int  NRD    = DEF_NRD,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [NRD-1:0]        rd_hold,
  input  logic [NRD-1:0]        rd_clear,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
`ifdef REGBANK_WR2_EN
  input  logic                  wr2_en,
  input  logic [ADDR_W-1:0]     wr2_addr,
  input  logic [DATA_W-1:0]     wr2_data,
`endif
  output logic [NRD*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_act;
  logic [DATA_W-1:0] wr_merged;

  assign wr_act    = wr_en && (wr_addr != '0);
  assign wr_merged = DATA_W'(byte_merge(MERGE_W'(mem[wr_addr]), MERGE_W'(wr_data),
                                        MERGE_BE'(wr_be)));

`ifdef REGBANK_WR2_EN
  logic wr2_act;
  assign wr2_act = wr2_en && (wr2_addr != '0);
`endif

  // Array is never reset; wr2 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_act) mem[wr_addr] <= wr_merged;
`ifdef REGBANK_WR2_EN
      if (wr2_act) mem[wr2_addr] <= wr2_data;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] port_addr;
      logic [DATA_W-1:0] arr_word;

      assign port_addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign arr_word  = mem[port_addr];

      regbank_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_rdport (
        .clk      (clk),
        .reset    (reset),
        .addr     (port_addr),
        .hold     (rd_hold[gi]),
        .clear    (rd_clear[gi]),
        .arr_word (arr_word),
        .wr_act   (wr_act),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
`ifdef REGBANK_WR2_EN
        .wr2_act  (wr2_act),
        .wr2_addr (wr2_addr),
        .wr2_data (wr2_data),
`endif
        .data     (rd_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule
